// File: rtl/bram_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : bram_pixel_fetch
// Purpose  : Maps the 640x480 raster position onto an RGB332 image held in a
//            1-cycle-latency BRAM placed at a fixed screen origin, issues the
//            read, applies a per-frame brightness mode with per-channel
//            saturation and delays the syncs so they stay aligned with the
//            pixel data (3-clock latency end to end).
// Ports    : clk                 - 25 MHz pixel clock
//            clear               - synchronous active-high reset
//            horizontal_counter  - raster column 0..799
//            vertical_counter    - raster line 0..524
//            output_signal       - active-video flag
//            hsync_in / vsync_in - active-low syncs from the timing generator
//            switch_sel          - brightness mode request
//            bram_dout           - BRAM read data {R[2:0],G[2:0],B[1:0]}
//            bram_addr / bram_en - BRAM read port
//            R_Pix/G_Pix/B_Pix   - registered colour outputs
//            hsync / vsync       - syncs delayed by 3 clocks
// Revision : 1.0 - initial release
// ============================================================================
module bram_pixel_fetch #(
   parameter int         IMG_W  = 160,
   parameter int         IMG_H  = 120,
   parameter int         X0     = 240,
   parameter int         Y0     = 180,
   parameter int         ADDR_W = 15,
   parameter logic [7:0] BORDER = 8'h00
) (
   input  logic              clk,
   input  logic              clear,
   input  logic [9:0]        horizontal_counter,
   input  logic [9:0]        vertical_counter,
   input  logic              output_signal,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [1:0]        switch_sel,
   input  logic [7:0]        bram_dout,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   output logic [2:0]        R_Pix,
   output logic [2:0]        G_Pix,
   output logic [1:0]        B_Pix,
   output logic              hsync,
   output logic              vsync
);

   // Counters are widened to 11 bits so X0+IMG_W / Y0+IMG_H never overflow.
   localparam logic [10:0]       c_x_lo   = 11'(X0);
   localparam logic [10:0]       c_x_hi   = 11'(X0 + IMG_W);
   localparam logic [10:0]       c_x_last = 11'(X0 + IMG_W - 1);
   localparam logic [10:0]       c_y_lo   = 11'(Y0);
   localparam logic [10:0]       c_y_hi   = 11'(Y0 + IMG_H);
   localparam logic [ADDR_W-1:0] c_img_w  = ADDR_W'(IMG_W);

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
   logic              bram_en_q;
   logic              in_img_s1_q, in_img_s2_q;
   logic              act_s1_q, act_s2_q;
   logic [1:0]        mode_q;
   logic [7:0]        pix_q, pix_d;
   logic [2:0]        hsync_sr_q, vsync_sr_q;

   // ---------------------------------------------------------------------
   // Stage 0: window decode
   // ---------------------------------------------------------------------
   logic [10:0] w_h, w_v, w_col;
   logic        w_in_x, w_in_y, w_in_img, w_line_end, w_frame_start;

   assign w_h           = {1'b0, horizontal_counter};
   assign w_v           = {1'b0, vertical_counter};
   assign w_in_x        = (w_h >= c_x_lo) && (w_h < c_x_hi);
   assign w_in_y        = (w_v >= c_y_lo) && (w_v < c_y_hi);
   assign w_in_img      = output_signal && w_in_x && w_in_y;
   assign w_line_end    = (w_h == c_x_last) && w_in_y;
   assign w_frame_start = (horizontal_counter == 10'd0) && (vertical_counter == 10'd0);
   // Wraps below X0; the address is don't-care there because bram_en is low.
   assign w_col         = w_h - c_x_lo;

   // Row base accumulates IMG_W per image line instead of multiplying v by
   // IMG_W. It is pinned to 0 above the image so any disturbance (including
   // a mid-frame reset) is healed before the next image starts.
   always_comb begin
      row_base_d = row_base_q;
      if (w_v < c_y_lo) begin
         row_base_d = '0;
      end else if (w_line_end) begin
         row_base_d = row_base_q + c_img_w;
      end
   end

   assign bram_addr_d = row_base_q + ADDR_W'(w_col);

   // ---------------------------------------------------------------------
   // Stage 3: brightness adjust with clamp. Each channel is computed one
   // bit wider; the extra bit flags overflow (add) or borrow (subtract).
   // ---------------------------------------------------------------------
   function automatic logic [2:0] adj3(input logic [2:0] v, input logic [1:0] inc,
                                       input logic dec);
      logic [3:0] w_sum;
      if (dec) w_sum = {1'b0, v} - 4'd1;
      else     w_sum = {1'b0, v} + {2'b00, inc};
      if (w_sum[3]) adj3 = dec ? 3'd0 : 3'd7;
      else          adj3 = w_sum[2:0];
   endfunction

   function automatic logic [1:0] adj2(input logic [1:0] v, input logic inc,
                                       input logic dec);
      logic [2:0] w_sum;
      if (dec) w_sum = {1'b0, v} - 3'd1;
      else     w_sum = {1'b0, v} + {2'b00, inc};
      if (w_sum[2]) adj2 = dec ? 2'd0 : 2'd3;
      else          adj2 = w_sum[1:0];
   endfunction

   logic [1:0] w_rg_inc;
   logic       w_b_inc;
   logic       w_dec;

   always_comb begin
      w_rg_inc = 2'd0;
      w_b_inc  = 1'b0;
      w_dec    = 1'b0;
      unique case (mode_q)
         2'b01:   begin w_rg_inc = 2'd1; w_b_inc = 1'b1; end
         2'b10:   w_dec = 1'b1;
         2'b11:   begin w_rg_inc = 2'd2; w_b_inc = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      pix_d = 8'h00;
      if (!act_s2_q) begin
         pix_d = 8'h00;
      end else if (!in_img_s2_q) begin
         pix_d = BORDER;
      end else begin
         pix_d = {adj3(bram_dout[7:5], w_rg_inc, w_dec),
                  adj3(bram_dout[4:2], w_rg_inc, w_dec),
                  adj2(bram_dout[1:0], w_b_inc, w_dec)};
      end
   end

   // ---------------------------------------------------------------------
   // Pipeline registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clear) begin
         row_base_q  <= '0;
         bram_addr_q <= '0;
         bram_en_q   <= 1'b0;
         in_img_s1_q <= 1'b0;
         in_img_s2_q <= 1'b0;
         act_s1_q    <= 1'b0;
         act_s2_q    <= 1'b0;
         mode_q      <= 2'b00;
         pix_q       <= 8'h00;
         hsync_sr_q  <= 3'b111;
         vsync_sr_q  <= 3'b111;
      end else begin
         row_base_q  <= row_base_d;
         bram_addr_q <= bram_addr_d;
         bram_en_q   <= w_in_img;
         in_img_s1_q <= w_in_img;
         in_img_s2_q <= in_img_s1_q;
         act_s1_q    <= output_signal;
         act_s2_q    <= act_s1_q;
         pix_q       <= pix_d;
         hsync_sr_q  <= {hsync_sr_q[1:0], hsync_in};
         vsync_sr_q  <= {vsync_sr_q[1:0], vsync_in};
         // Mode only changes at the frame origin so a frame never tears.
         if (w_frame_start) begin
            mode_q <= switch_sel;
         end
      end
   end

   assign bram_addr = bram_addr_q;
   assign bram_en   = bram_en_q;
   assign R_Pix     = pix_q[7:5];
   assign G_Pix     = pix_q[4:2];
   assign B_Pix     = pix_q[1:0];
   assign hsync     = hsync_sr_q[2];
   assign vsync     = vsync_sr_q[2];

endmodule
`default_nettype wire

// File: tb/tb_bram_pixel_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bram_pixel_fetch
// Purpose  : Scoreboard bench for bram_pixel_fetch. The driver pushes the
//            expected colour/sync word and BRAM address for every cycle it
//            issues; a negedge monitor pops entries when they fall due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_pixel_fetch;

   localparam int         IMG_W  = 160;
   localparam int         IMG_H  = 120;
   localparam int         X0     = 240;
   localparam int         Y0     = 180;
   localparam int         ADDR_W = 15;
   localparam logic [7:0] BORDER = 8'hE0;

   logic              clk = 1'b0;
   logic              clear = 1'b1;
   logic [9:0]        horizontal_counter = '0;
   logic [9:0]        vertical_counter = '0;
   logic              output_signal = 1'b0;
   logic              hsync_in = 1'b1;
   logic              vsync_in = 1'b1;
   logic [1:0]        switch_sel = 2'b00;
   logic [7:0]        bram_dout = 8'h00;
   logic [ADDR_W-1:0] bram_addr;
   logic              bram_en;
   logic [2:0]        R_Pix, G_Pix;
   logic [1:0]        B_Pix;
   logic              hsync, vsync;

   bram_pixel_fetch #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0),
      .ADDR_W(ADDR_W), .BORDER(BORDER)
   ) dut (
      .clk(clk), .clear(clear),
      .horizontal_counter(horizontal_counter), .vertical_counter(vertical_counter),
      .output_signal(output_signal), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .switch_sel(switch_sel), .bram_dout(bram_dout),
      .bram_addr(bram_addr), .bram_en(bram_en),
      .R_Pix(R_Pix), .G_Pix(G_Pix), .B_Pix(B_Pix),
      .hsync(hsync), .vsync(vsync)
   );

   always #20 clk = ~clk;

   // BRAM model: 1-cycle read latency, data = address low byte or a constant
   bit         use_const = 1'b0;
   logic [7:0] const_val = 8'h00;
   always @(posedge clk) begin
      if (bram_en === 1'b1) bram_dout <= use_const ? const_val : bram_addr[7:0];
   end

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct { int due; logic [7:0] rgb; logic hs; logic vs; int spot; } pix_t;
   typedef struct { int due; int addr; int spot; } adr_t;
   pix_t pix_q[$];
   adr_t adr_q[$];

   int  n_chk = 0;
   int  n_fail = 0;
   int  en_cnt = 0;
   int  mon_from = 32'h3FFF_FFFF;
   int  exp_mode = 0;
   bit  prev_clear = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, expv, edge_n);
      end
   endtask

   function automatic logic [7:0] adjust(input logic [7:0] d, input int m);
      int r, g, b;
      r = int'(d[7:5]); g = int'(d[4:2]); b = int'(d[1:0]);
      case (m)
         1: begin r = r + 1; g = g + 1; b = b + 1; end
         2: begin r = r - 1; g = g - 1; b = b - 1; end
         3: begin r = r + 2; g = g + 2; b = b + 1; end
         default: ;
      endcase
      if (r > 7) r = 7;
      if (r < 0) r = 0;
      if (g > 7) g = 7;
      if (g < 0) g = 0;
      if (b > 3) b = 3;
      if (b < 0) b = 0;
      return {r[2:0], g[2:0], b[1:0]};
   endfunction

   // Hand-computed addresses at the image corners.
   function automatic int spot_addr(input int h, input int v);
      if (h == 240 && v == 180) return 0;
      if (h == 399 && v == 180) return 159;
      if (h == 240 && v == 181) return 160;
      if (h == 399 && v == 299) return 19199;
      return -1;
   endfunction

   function automatic pix_t reset_entry(input int due);
      pix_t p;
      p.due = due; p.rgb = 8'h00; p.hs = 1'b1; p.vs = 1'b1; p.spot = -1;
      return p;
   endfunction

   // Apply one cycle of inputs (called at posedge+2) and queue expectations.
   task automatic drive(input int h, input int v, input bit os, input bit hs,
                        input bit vs, input logic [1:0] sw, input bit clr);
      int         e;
      bit         inimg;
      pix_t       p;
      adr_t       a;
      logic [7:0] d;
      horizontal_counter = 10'(h);
      vertical_counter   = 10'(v);
      output_signal      = os;
      hsync_in           = hs;
      vsync_in           = vs;
      switch_sel         = sw;
      clear              = clr;
      e = edge_n + 1;
      if (clr) begin
         if (mon_from > e) mon_from = e;
         while (pix_q.size() > 0 && pix_q[$].due >= e) void'(pix_q.pop_back());
         while (adr_q.size() > 0 && adr_q[$].due >= e) void'(adr_q.pop_back());
         exp_mode = 0;
         pix_q.push_back(reset_entry(e));
      end else begin
         if (prev_clear) begin
            pix_q.push_back(reset_entry(e));
            pix_q.push_back(reset_entry(e + 1));
         end
         inimg = os && h >= X0 && h < X0 + IMG_W && v >= Y0 && v < Y0 + IMG_H;
         p.due = e + 2; p.hs = hs; p.vs = vs; p.spot = -1;
         if (!os) begin
            p.rgb = 8'h00;
         end else if (!inimg) begin
            p.rgb = BORDER;
         end else begin
            a.addr = (v - Y0) * IMG_W + (h - X0);
            a.due  = e;
            a.spot = spot_addr(h, v);
            d = use_const ? const_val : 8'(a.addr);
            p.rgb = adjust(d, exp_mode);
            if (h == 245 && v == 180 && !use_const && exp_mode == 0) p.spot = 8'h05;
            adr_q.push_back(a);
         end
         pix_q.push_back(p);
         if (h == 0 && v == 0) exp_mode = int'(sw);
      end
      prev_clear = clr;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(650, 300, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
   endtask

   task automatic rand_reset(input int n);
      for (int i = 0; i < n; i++)
         drive(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
               1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'b1);
   endtask

   task automatic sat(input logic [7:0] val, input logic [1:0] m);
      const_val = val;
      drive(0, 0, 1'b0, 1'b1, 1'b0, m, 1'b0);
      drive(1, 0, 1'b0, 1'b1, 1'b1, m, 1'b0);
      for (int h = X0; h < X0 + 3; h++) drive(h, Y0, 1'b1, 1'b1, 1'b1, m, 1'b0);
      idle(3);
   endtask

   // Compressed frame: only the image window (plus a margin) is scanned.
   task automatic frame(input logic [1:0] sw0, input logic [1:0] sw1, input int chg_v);
      logic [1:0] sw;
      int         base;
      base = en_cnt;
      drive(0, 0, 1'b0, 1'b1, 1'b0, sw0, 1'b0);
      drive(1, 0, 1'b0, 1'b1, 1'b0, sw0, 1'b0);
      drive(100, 100, 1'b1, 1'b1, 1'b1, sw0, 1'b0);
      drive(700, 179, 1'b0, 1'b1, 1'b1, sw0, 1'b0);
      sw = sw0;
      for (int v = Y0; v < Y0 + IMG_H; v++) begin
         sw = (v >= chg_v) ? sw1 : sw0;
         for (int h = X0 - 4; h < X0 + IMG_W + 4; h++) drive(h, v, 1'b1, 1'b1, 1'b1, sw, 1'b0);
         drive(650, v, 1'b0, 1'b0, 1'b1, sw, 1'b0);
      end
      idle(4);
      chk("bram_en_count", 32'(en_cnt - base), 32'd19200);
   endtask

   // Monitor
   pix_t mp;
   adr_t ma;
   always @(negedge clk) begin
      if (edge_n >= mon_from) begin
         while (pix_q.size() > 0 && pix_q[0].due < edge_n) begin
            mp = pix_q.pop_front();
            chk("pix_stale", 32'(mp.due), 32'(edge_n));
         end
         if (pix_q.size() > 0 && pix_q[0].due == edge_n) begin
            mp = pix_q.pop_front();
            chk("rgb", 32'({R_Pix, G_Pix, B_Pix}), 32'(mp.rgb));
            chk("hsync", 32'(hsync), 32'(mp.hs));
            chk("vsync", 32'(vsync), 32'(mp.vs));
            if (mp.spot >= 0) chk("align_pixel", 32'({R_Pix, G_Pix, B_Pix}), 32'(mp.spot));
         end
         if (bram_en === 1'b1) en_cnt++;
         while (adr_q.size() > 0 && adr_q[0].due < edge_n) begin
            ma = adr_q.pop_front();
            chk("addr_stale", 32'(ma.due), 32'(edge_n));
         end
         if (adr_q.size() > 0 && adr_q[0].due == edge_n) begin
            ma = adr_q.pop_front();
            chk("bram_en", 32'(bram_en), 32'd1);
            chk("bram_addr", 32'(bram_addr), 32'(ma.addr));
            if (ma.spot >= 0) chk("addr_corner", 32'(bram_addr), 32'(ma.spot));
         end else begin
            chk("bram_en_idle", 32'(bram_en), 32'd0);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #2;
      // Reset with random inputs, then check the mode register was cleared
      rand_reset(4);
      idle(2);
      drive(0, 0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
      idle(2);
      rand_reset(4);
      use_const = 1'b1;
      const_val = 8'h49;
      drive(X0, Y0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
      drive(X0 + 1, Y0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
      idle(3);
      // Saturation / floor
      sat(8'hFF, 2'b01);
      sat(8'h00, 2'b10);
      sat(8'b110_101_10, 2'b11);
      use_const = 1'b0;
      // Border and blanking
      drive(100, 100, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
      drive(700, 100, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
      drive(639, 479, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
      idle(3);
      // Frame with mid-frame switch change, then a frame using the new mode
      frame(2'b00, 2'b01, 200);
      frame(2'b01, 2'b01, 1000);
      // Reset asserted in the middle of image pixels
      drive(650, 0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
      drive(X0, Y0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
      drive(X0 + 1, Y0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
      drive(X0 + 2, Y0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
      idle(4);
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      chk("queues_drained", 32'(pix_q.size() + adr_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
